uc_dispatch_sched: RTL and testbench

- Scheduler between the solver engines and the unit-clause queue/arbiter.
- Collection path: round-robin arbitration among NUM_ENGINE engines producing unit clauses (UCs), serialising them into one registered output stream toward the UC arbiter.
- Broadcast path: takes each UC popped from the UC queue and delivers it to every engine, respecting per-engine full flags, before accepting the next.
- Global halt on conflict freezes both paths.

---
 rtl/uc_dispatch_sched.sv | 141 ++++++++++++++
 tb/tb_uc_dispatch_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uc_dispatch_sched.sv
// Unit-clause scheduler: round-robin collection from engines plus queue-to-engine broadcast.
// Optional broadcast stall timeout is enabled with `define UC_SCHED_TIMEOUT_EN.
module uc_dispatch_sched #(
    parameter int NUM_ENGINE = 4,
    parameter int LIT_W      = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_ENGINE-1:0]       eng_valid,
    input  logic [NUM_ENGINE*LIT_W-1:0] eng_uc,
    output logic [NUM_ENGINE-1:0]       eng_grant,
    output logic                        out_valid,
    output logic [LIT_W-1:0]            out_uc,
    input  logic                        out_ready,
    input  logic                        bc_valid,
    input  logic [LIT_W-1:0]            bc_uc,
    output logic                        bc_pop,
    input  logic [NUM_ENGINE-1:0]       eng_full,
    output logic [NUM_ENGINE-1:0]       bc_push,
    output logic [LIT_W-1:0]            bc_data,
    input  logic                        halt,
`ifdef UC_SCHED_TIMEOUT_EN
    output logic                        bc_timeout,
`endif
    output logic                        busy
);

    localparam int PTR_W = $clog2(NUM_ENGINE);

    typedef enum logic [1:0] {B_IDLE, B_SEND, B_HALT} bc_state_t;

    bc_state_t             bc_state;
    logic [PTR_W-1:0]      rr_ptr;
    logic [NUM_ENGINE-1:0] pending;
    logic                  can_load;
    logic                  frozen;
    logic                  grant_any;
    logic [PTR_W-1:0]      grant_idx;
    logic [PTR_W-1:0]      grant_next;
    int unsigned           scan_idx;

`ifdef UC_SCHED_TIMEOUT_EN
    logic [15:0]           stall_cnt;
`endif

    // Strobes are suppressed in the cycle halt is seen, in B_HALT, and while reset is held.
    assign frozen   = halt | rst | (bc_state == B_HALT);
    assign can_load = ~out_valid | out_ready;
    assign busy     = (bc_state == B_SEND) | out_valid;

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = 0;
        eng_grant = '0;
        if (can_load && !frozen) begin
            for (int unsigned k = 0; k < NUM_ENGINE; k++) begin
                scan_idx = 32'(rr_ptr) + k;
                if (scan_idx >= NUM_ENGINE) scan_idx = scan_idx - NUM_ENGINE;
                if (!grant_any && eng_valid[scan_idx]) begin
                    grant_any = 1'b1;
                    grant_idx = PTR_W'(scan_idx);
                end
            end
        end
        if (grant_any) eng_grant[grant_idx] = 1'b1;
    end

    assign grant_next = (grant_idx == PTR_W'(NUM_ENGINE - 1)) ? '0 : grant_idx + PTR_W'(1);

    assign bc_pop  = (bc_state == B_IDLE) & bc_valid & ~frozen;
    assign bc_push = ((bc_state == B_SEND) && !frozen) ? (pending & ~eng_full) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_uc    <= '0;
            rr_ptr    <= '0;
        end else if (halt) begin
            out_valid <= 1'b0;
        end else if (grant_any) begin
            out_valid <= 1'b1;
            out_uc    <= eng_uc[grant_idx*LIT_W +: LIT_W];
            rr_ptr    <= grant_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bc_state   <= B_IDLE;
            pending    <= '0;
            bc_data    <= '0;
`ifdef UC_SCHED_TIMEOUT_EN
            stall_cnt  <= '0;
            bc_timeout <= 1'b0;
`endif
        end else if (halt) begin
            bc_state <= B_HALT;
            pending  <= '0;
`ifdef UC_SCHED_TIMEOUT_EN
            stall_cnt <= '0;
`endif
        end else begin
            case (bc_state)
                B_IDLE: begin
`ifdef UC_SCHED_TIMEOUT_EN
                    stall_cnt <= '0;
`endif
                    if (bc_pop) begin
                        bc_data  <= bc_uc;
                        pending  <= '1;
                        bc_state <= B_SEND;
                    end
                end
                B_SEND: begin
                    pending <= pending & ~bc_push;
                    if ((pending & ~bc_push) == '0) bc_state <= B_IDLE;
`ifdef UC_SCHED_TIMEOUT_EN
                    if (bc_push != '0) begin
                        stall_cnt <= '0;
                    end else if (pending != '0) begin
                        if (stall_cnt == '1) begin
                            pending    <= '0;
                            bc_state   <= B_IDLE;
                            bc_timeout <= 1'b1;
                            stall_cnt  <= '0;
                        end else begin
                            stall_cnt <= stall_cnt + 16'd1;
                        end
                    end
`endif
                end
                B_HALT: bc_state <= B_HALT;
                default: bc_state <= B_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uc_dispatch_sched.sv
// Directed testbench for uc_dispatch_sched with hand-computed expectations.
module tb_uc_dispatch_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  eng_valid;
    logic [31:0] eng_uc;
    logic [3:0]  eng_grant;
    logic        out_valid;
    logic [7:0]  out_uc;
    logic        out_ready;
    logic        bc_valid;
    logic [7:0]  bc_uc;
    logic        bc_pop;
    logic [3:0]  eng_full;
    logic [3:0]  bc_push;
    logic [7:0]  bc_data;
    logic        halt;
    logic        busy;
`ifdef UC_SCHED_TIMEOUT_EN
    logic        bc_timeout;
`endif

    int checks   = 0;
    int failures = 0;
    int pop_count = 0;

    uc_dispatch_sched #(.NUM_ENGINE(4), .LIT_W(8)) dut (
        .clk(clk), .rst(rst),
        .eng_valid(eng_valid), .eng_uc(eng_uc), .eng_grant(eng_grant),
        .out_valid(out_valid), .out_uc(out_uc), .out_ready(out_ready),
        .bc_valid(bc_valid), .bc_uc(bc_uc), .bc_pop(bc_pop),
        .eng_full(eng_full), .bc_push(bc_push), .bc_data(bc_data),
        .halt(halt),
`ifdef UC_SCHED_TIMEOUT_EN
        .bc_timeout(bc_timeout),
`endif
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bc_pop === 1'b1) pop_count++;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1;
        checks++; if ({eng_grant, out_valid, out_uc, bc_pop, bc_push, bc_data, busy} !== '0) begin
            failures++; $display("FAIL reset_outputs got grant=%b ov=%b uc=%h pop=%b push=%b data=%h busy=%b exp all 0",
                eng_grant, out_valid, out_uc, bc_pop, bc_push, bc_data, busy); end
        tick; tick;
        rst = 1'b0;
        #1;
        checks++; if ({out_valid, busy, bc_push} !== '0) begin
            failures++; $display("FAIL reset_release got ov=%b busy=%b push=%b exp 0", out_valid, busy, bc_push); end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_g;
        for (int i = 0; i < 4; i++) eng_uc[i*8 +: 8] = 8'(i + 1);
        eng_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            exp_g = 4'b0001 << (k % 4);
            checks++; if (eng_grant !== exp_g) begin
                failures++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, eng_grant, exp_g); end
            tick;
            checks++; if (out_valid !== 1'b1 || out_uc !== 8'((k % 4) + 1)) begin
                failures++; $display("FAIL rr_out k=%0d got ov=%b uc=%h exp ov=1 uc=%h", k, out_valid, out_uc, 8'((k % 4) + 1)); end
        end
        eng_valid = 4'b0000;
        tick;
        checks++; if (out_valid !== 1'b0) begin
            failures++; $display("FAIL rr_drain got ov=%b exp 0", out_valid); end
    endtask

    task automatic test_backpressure;
        eng_uc[7:0] = 8'h05;
        eng_valid = 4'b0001;
        out_ready = 1'b0;
        #1;
        checks++; if (eng_grant !== 4'b0001) begin
            failures++; $display("FAIL bp_load_grant got=%b exp=0001", eng_grant); end
        tick;
        eng_valid = 4'b0100;
        eng_uc[23:16] = 8'h33;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (eng_grant !== 4'b0000 || out_valid !== 1'b1 || out_uc !== 8'h05) begin
                failures++; $display("FAIL bp_hold k=%0d got grant=%b ov=%b uc=%h exp grant=0000 ov=1 uc=05", k, eng_grant, out_valid, out_uc); end
            tick;
        end
        out_ready = 1'b1;
        #1;
        checks++; if (eng_grant !== 4'b0100) begin
            failures++; $display("FAIL bp_release_grant got=%b exp=0100", eng_grant); end
        tick;
        checks++; if (out_valid !== 1'b1 || out_uc !== 8'h33) begin
            failures++; $display("FAIL bp_next_uc got ov=%b uc=%h exp ov=1 uc=33", out_valid, out_uc); end
        eng_valid = 4'b0000;
        tick;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin
            failures++; $display("FAIL bp_drain got ov=%b exp 0", out_valid); end
    endtask

    task automatic test_broadcast;
        bc_uc = 8'hFD;
        bc_valid = 1'b1;
        eng_full = 4'b0000;
        #1;
        checks++; if (bc_pop !== 1'b1 || bc_push !== 4'b0000) begin
            failures++; $display("FAIL bc_pop1 got pop=%b push=%b exp pop=1 push=0000", bc_pop, bc_push); end
        tick;
        checks++; if (bc_pop !== 1'b0 || bc_push !== 4'b1111 || bc_data !== 8'hFD || busy !== 1'b1) begin
            failures++; $display("FAIL bc_send got pop=%b push=%b data=%h busy=%b exp pop=0 push=1111 data=fd busy=1", bc_pop, bc_push, bc_data, busy); end
        tick;
        checks++; if (bc_pop !== 1'b1 || bc_push !== 4'b0000) begin
            failures++; $display("FAIL bc_pop2 got pop=%b push=%b exp pop=1 push=0000", bc_pop, bc_push); end
        bc_valid = 1'b0;
        #1;
        checks++; if (bc_pop !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL bc_idle got pop=%b busy=%b exp 0 0", bc_pop, busy); end
    endtask

    task automatic test_partial_full;
        int p0;
        p0 = pop_count;
        bc_uc = 8'h42;
        bc_valid = 1'b1;
        eng_full = 4'b0010;
        #1;
        checks++; if (bc_pop !== 1'b1) begin
            failures++; $display("FAIL pf_pop got=%b exp=1", bc_pop); end
        tick;
        bc_valid = 1'b0;
        #1;
        checks++; if (bc_push !== 4'b1101 || bc_data !== 8'h42) begin
            failures++; $display("FAIL pf_first got push=%b data=%h exp push=1101 data=42", bc_push, bc_data); end
        tick;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (bc_push !== 4'b0000 || busy !== 1'b1 || bc_data !== 8'h42) begin
                failures++; $display("FAIL pf_stall k=%0d got push=%b busy=%b data=%h exp push=0000 busy=1 data=42", k, bc_push, busy, bc_data); end
            tick;
        end
        eng_full = 4'b0000;
        #1;
        checks++; if (bc_push !== 4'b0010) begin
            failures++; $display("FAIL pf_last got push=%b exp=0010", bc_push); end
        tick;
        #1;
        checks++; if (busy !== 1'b0 || bc_push !== 4'b0000 || (pop_count - p0) !== 1) begin
            failures++; $display("FAIL pf_done got busy=%b push=%b pops=%0d exp busy=0 push=0000 pops=1", busy, bc_push, pop_count - p0); end
    endtask

    task automatic test_halt;
        bc_uc = 8'h77;
        bc_valid = 1'b1;
        eng_full = 4'b1000;
        eng_valid = 4'b0001;
        out_ready = 1'b0;
        #1;
        checks++; if (eng_grant !== 4'b0001 || bc_pop !== 1'b1) begin
            failures++; $display("FAIL halt_setup got grant=%b pop=%b exp grant=0001 pop=1", eng_grant, bc_pop); end
        tick;
        bc_valid = 1'b0;
        eng_valid = 4'b0000;
        #1;
        checks++; if (bc_push !== 4'b0111 || out_valid !== 1'b1) begin
            failures++; $display("FAIL halt_pre got push=%b ov=%b exp push=0111 ov=1", bc_push, out_valid); end
        tick;
        halt = 1'b1;
        eng_full = 4'b0000;
        eng_valid = 4'b1111;
        out_ready = 1'b1;
        bc_valid = 1'b1;
        #1;
        checks++; if (bc_push !== 4'b0000 || eng_grant !== 4'b0000 || bc_pop !== 1'b0) begin
            failures++; $display("FAIL halt_comb got push=%b grant=%b pop=%b exp all 0", bc_push, eng_grant, bc_pop); end
        tick;
        halt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if ({out_valid, busy, bc_push, eng_grant, bc_pop} !== '0) begin
                failures++; $display("FAIL halt_hold k=%0d got ov=%b busy=%b push=%b grant=%b pop=%b exp all 0", k, out_valid, busy, bc_push, eng_grant, bc_pop); end
            tick;
        end
    endtask

    task automatic test_async_reset;
        rst = 1'b1;
        bc_valid = 1'b0;
        eng_valid = 4'b0000;
        out_ready = 1'b0;
        tick;
        rst = 1'b0;
        bc_uc = 8'h5A;
        bc_valid = 1'b1;
        eng_full = 4'b1111;
        eng_valid = 4'b0010;
        eng_uc[15:8] = 8'h22;
        #1;
        checks++; if (eng_grant !== 4'b0010 || bc_pop !== 1'b1) begin
            failures++; $display("FAIL ar_setup got grant=%b pop=%b exp grant=0010 pop=1", eng_grant, bc_pop); end
        tick;
        bc_valid = 1'b0;
        eng_valid = 4'b0000;
        #1;
        checks++; if (busy !== 1'b1 || out_valid !== 1'b1 || out_uc !== 8'h22 || bc_data !== 8'h5A) begin
            failures++; $display("FAIL ar_mid got busy=%b ov=%b uc=%h data=%h exp busy=1 ov=1 uc=22 data=5a", busy, out_valid, out_uc, bc_data); end
        #1;
        rst = 1'b1;
        eng_valid = 4'b1111;
        bc_valid = 1'b1;
        #1;
        checks++; if ({eng_grant, out_valid, out_uc, bc_pop, bc_push, bc_data, busy} !== '0) begin
            failures++; $display("FAIL ar_outputs got grant=%b ov=%b uc=%h pop=%b push=%b data=%h busy=%b exp all 0",
                eng_grant, out_valid, out_uc, bc_pop, bc_push, bc_data, busy); end
        #2;
        rst = 1'b0;
        bc_valid = 1'b0;
        eng_full = 4'b0000;
        out_ready = 1'b1;
        #1;
        checks++; if (eng_grant !== 4'b0001 || bc_push !== 4'b0000) begin
            failures++; $display("FAIL ar_first_grant got grant=%b push=%b exp grant=0001 push=0000", eng_grant, bc_push); end
        tick;
        checks++; if (out_valid !== 1'b1 || out_uc !== 8'h05) begin
            failures++; $display("FAIL ar_first_uc got ov=%b uc=%h exp ov=1 uc=05", out_valid, out_uc); end
        eng_valid = 4'b0000;
    endtask

    initial begin
        rst = 1'b1;
        eng_valid = '0;
        eng_uc = '0;
        out_ready = 1'b0;
        bc_valid = 1'b0;
        bc_uc = '0;
        eng_full = '0;
        halt = 1'b0;
        test_reset;
        test_round_robin;
        test_backpressure;
        test_broadcast;
        test_partial_full;
        test_halt;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
